// File: rtl/fp_unpack.sv
// fp_unpack: splits a packed IEEE double or single operand into sign,
// double-biased exponent, 64-bit significand with explicit integer bit,
// and class flags. Denormals are normalized over several cycles, at most
// 8 bit positions per cycle.
//
// Ports
//   clk, reset_n         clock, async active-low reset
//   in_valid / in_ready  operand handshake (op, P sampled on transfer)
//   op[63:0]             double in [63:0], single in [63:32]
//   P[1:0]               P[0]=1 single, P[0]=0 double
//   out_valid/out_ready  result handshake
//   Asign, Aexp[11:0]    sign, two's-complement exponent, bias 1023
//   Amant[63:0]          significand, bit 63 = integer bit
//   norm_shift[5:0]      total left shift applied to a denormal
//   Azero/Adenorm/Ainf/Anan  class flags; Invalid = signaling NaN
module fp_unpack (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] op,
  input  logic [1:0]  P,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        Asign,
  output logic [11:0] Aexp,
  output logic [63:0] Amant,
  output logic [5:0]  norm_shift,
  output logic        Azero,
  output logic        Adenorm,
  output logic        Ainf,
  output logic        Anan,
  output logic        Invalid
);

  typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;
  state_t state, state_nxt;

  logic accept;

  // Operand decode. The single fraction is left-aligned into the 52-bit
  // field so both precisions land in Amant[62:11] through the same path.
  logic        exp_zero, exp_ones, frac_nz;
  logic [51:0] frac_f;
  logic [11:0] exp_norm, exp_den;
  logic [11:0] ld_exp;
  logic [63:0] ld_mant;
  logic        is_den;

  always_comb begin
    if (P[0]) begin
      exp_zero = (op[62:55] == 8'd0);
      exp_ones = &op[62:55];
      frac_f   = {op[54:32], 29'd0};
      exp_norm = {4'd0, op[62:55]} + 12'd896;
      exp_den  = 12'd897;
    end else begin
      exp_zero = (op[62:52] == 11'd0);
      exp_ones = &op[62:52];
      frac_f   = op[51:0];
      exp_norm = {1'b0, op[62:52]};
      exp_den  = 12'd1;
    end
    frac_nz = |frac_f;
    is_den  = exp_zero & frac_nz;
    // Hidden bit only for normals; zero falls out as all-zero.
    ld_mant = {~exp_zero & ~exp_ones, frac_f, 11'd0};
    if (exp_ones)      ld_exp = 12'd2047;
    else if (is_den)   ld_exp = exp_den;
    else if (exp_zero) ld_exp = 12'd0;
    else               ld_exp = exp_norm;
  end

  // Leading-zero count of the top byte; only used when the byte is nonzero.
  logic       top_zero;
  logic [2:0] lz;

  always_comb begin
    top_zero = ~|Amant[63:56];
    lz = 3'd0;
    for (int i = 0; i < 8; i++)
      if (Amant[56+i]) lz = 3'(7 - i);
  end

  // Handshake and next-state
  always_comb begin
    in_ready  = (state == IDLE) | ((state == HOLD) & out_ready);
    out_valid = (state == HOLD);
    accept    = in_valid & in_ready;
    state_nxt = state;
    unique case (state)
      IDLE: ;
      NORM: if (!top_zero) state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Acceptance only happens in IDLE or HOLD, so it overrides the above.
    if (accept) state_nxt = is_den ? NORM : HOLD;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Asign      <= 1'b0;
      Aexp       <= 12'd0;
      Amant      <= 64'd0;
      norm_shift <= 6'd0;
      Azero      <= 1'b0;
      Adenorm    <= 1'b0;
      Ainf       <= 1'b0;
      Anan       <= 1'b0;
      Invalid    <= 1'b0;
    end else if (accept) begin
      Asign      <= op[63];
      Aexp       <= ld_exp;
      Amant      <= ld_mant;
      norm_shift <= 6'd0;
      Azero      <= exp_zero & ~frac_nz;
      Adenorm    <= is_den;
      Ainf       <= exp_ones & ~frac_nz;
      Anan       <= exp_ones & frac_nz;
      Invalid    <= exp_ones & frac_nz & ~frac_f[51];
    end else if (state == NORM) begin
      if (top_zero) begin
        Amant      <= Amant << 8;
        Aexp       <= Aexp - 12'd8;
        norm_shift <= norm_shift + 6'd8;
      end else begin
        Amant      <= Amant << lz;
        Aexp       <= Aexp - {9'd0, lz};
        norm_shift <= norm_shift + {3'd0, lz};
      end
    end
  end

endmodule

// File: tb/tb_fp_unpack.sv
// Directed bench for fp_unpack: class decode, denormal normalization
// latency, backpressure, streaming and reset abandonment.
module tb_fp_unpack;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [63:0] op;
  logic [1:0]  P;
  logic        out_valid, out_ready;
  logic        Asign;
  logic [11:0] Aexp;
  logic [63:0] Amant;
  logic [5:0]  norm_shift;
  logic        Azero, Adenorm, Ainf, Anan, Invalid;

  int n_chk  = 0;
  int n_fail = 0;

  fp_unpack dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .P(P),
    .out_valid(out_valid), .out_ready(out_ready),
    .Asign(Asign), .Aexp(Aexp), .Amant(Amant), .norm_shift(norm_shift),
    .Azero(Azero), .Adenorm(Adenorm), .Ainf(Ainf), .Anan(Anan),
    .Invalid(Invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One operand end to end. While waiting, in_valid stays high with a
  // different operand to show it is ignored during NORM / stalled HOLD.
  // fl = {Azero, Adenorm, Ainf, Anan, Invalid}
  task automatic run(input string tag, input logic [63:0] o, input logic [1:0] p,
                     input int lat, input logic s, input logic [11:0] e,
                     input logic [63:0] m, input logic [5:0] ns, input logic [4:0] fl);
    int cyc;
    out_ready = 1'b0;
    op = o; P = p; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 64'h3FF0_0000_0000_0000; P = 2'b00;
    cyc = 1;
    if (lat > 1) chk({tag, "_rdy_norm"}, in_ready, 0);
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_sign"}, Asign, s);
    chk({tag, "_exp"}, Aexp, e);
    chk({tag, "_mant"}, Amant, m);
    chk({tag, "_shift"}, norm_shift, ns);
    chk({tag, "_flags"}, {Azero, Adenorm, Ainf, Anan, Invalid}, fl);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_drop"}, out_valid, 0);
    out_ready = 1'b0;
  endtask

  logic [63:0] sops [4];
  logic [11:0] sexp [4];
  logic        stale;

  initial begin
    sops = '{64'h4000_0000_0000_0000, 64'h4010_0000_0000_0000,
             64'h4020_0000_0000_0000, 64'h3FE0_0000_0000_0000};
    sexp = '{12'd1024, 12'd1025, 12'd1026, 12'd1022};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; P = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_exp", Aexp, 0);
    chk("rst_mant", Amant, 0);
    chk("rst_misc", {Asign, norm_shift, Azero, Adenorm, Ainf, Anan, Invalid}, 0);
    reset_n = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1);

    run("d_one",   64'h3FF0_0000_0000_0000, 2'b00, 1, 0, 12'd1023, 64'h8000_0000_0000_0000, 0, 5'b00000);
    run("s_one",   64'h3F80_0000_DEAD_BEEF, 2'b11, 1, 0, 12'd1023, 64'h8000_0000_0000_0000, 0, 5'b00000);
    run("s_max",   64'h7F7F_FFFF_0000_0000, 2'b01, 1, 0, 12'd1150, 64'hFFFF_FF00_0000_0000, 0, 5'b00000);
    run("d_neg2",  64'hC000_0000_0000_0000, 2'b00, 1, 1, 12'h400,  64'h8000_0000_0000_0000, 0, 5'b00000);
    run("d_dmin",  64'h0000_0000_0000_0001, 2'b00, 8, 0, 12'hFCD,  64'h8000_0000_0000_0000, 52, 5'b01000);
    run("d_dmax",  64'h0008_0000_0000_0000, 2'b00, 2, 0, 12'h000,  64'h8000_0000_0000_0000, 1, 5'b01000);
    run("d_dmid",  64'h0000_0000_0000_0100, 2'b00, 7, 0, 12'hFD5,  64'h8000_0000_0000_0000, 44, 5'b01000);
    run("s_dmin",  64'h0000_0001_0000_0000, 2'b01, 4, 0, 12'd874,  64'h8000_0000_0000_0000, 23, 5'b01000);
    run("d_snan",  64'h7FF0_0000_0000_0001, 2'b00, 1, 0, 12'd2047, 64'h0000_0000_0000_0800, 0, 5'b00011);
    run("d_qnan",  64'h7FF8_0000_0000_0000, 2'b00, 1, 0, 12'd2047, 64'h4000_0000_0000_0000, 0, 5'b00010);
    run("d_ninf",  64'hFFF0_0000_0000_0000, 2'b00, 1, 1, 12'd2047, 64'h0,                   0, 5'b00100);
    run("d_nzero", 64'h8000_0000_0000_0000, 2'b00, 1, 1, 12'd0,    64'h0,                   0, 5'b10000);
    run("s_snan",  64'h7F80_0001_0000_0000, 2'b01, 1, 0, 12'd2047, 64'h0000_0100_0000_0000, 0, 5'b00011);
    run("s_zero",  64'h0000_0000_FFFF_FFFF, 2'b01, 1, 0, 12'd0,    64'h0,                   0, 5'b10000);

    // Backpressure: result must hold while out_ready is low.
    op = 64'h3FF0_0000_0000_0000; P = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_exp", Aexp, 12'd1023);
      @(posedge clk); #1;
    end

    // Streaming: one result per cycle, in order.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; op = sops[k];
      @(posedge clk); #1;
      chk("st_valid", out_valid, 1);
      chk("st_exp", Aexp, sexp[k]);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("st_idle", out_valid, 0);
    out_ready = 1'b0;

    // Reset during the third NORM cycle of the minimum double denormal.
    op = 64'h0000_0000_0000_0001; P = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_mant", Amant, 0);
    chk("mr_exp", Aexp, 0);
    chk("mr_misc", {norm_shift, Adenorm}, 0);
    chk("mr_ready", in_ready, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    stale = 1'b0;
    out_ready = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    chk("mr_stale", stale, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_unpack.md
FP_UNPACK -- requirements
Module: fp_unpack

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  packed operand presented.
REQ-005 in_ready  out  1  block can accept; transfer occurs when in_valid & in_ready at a rising edge.
REQ-006 op  in  64  packed IEEE operand; double in [63:0], single in [63:32] ([31:0] ignored).
REQ-007 P  in  2  precision; P[0]=1 single, P[0]=0 double; P[1] ignored.
REQ-008 out_valid  out  1  unpacked result valid.
REQ-009 out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
REQ-010 Asign  out  1  operand sign.
REQ-011 Aexp  out  12  two's-complement exponent in double bias (1023).
REQ-012 Amant  out  64  significand; bit 63 is the integer bit; double fraction at [62:11], single fraction at [62:40]; all other bits zero.
REQ-013 norm_shift  out  6  total left shift applied to a denormal.
REQ-014 Azero, Adenorm, Ainf, Anan  out  1 each  operand class, one-hot or all zero for normals.
REQ-015 Invalid  out  1  operand is a signaling NaN (fraction MSB = 0, fraction nonzero).

Function
REQ-016 The FSM SHALL have states IDLE, NORM and HOLD; in_ready = IDLE | (HOLD & out_ready); out_valid = HOLD.
REQ-017 On acceptance of a normal, zero, infinity or NaN operand, all outputs SHALL be registered on the acceptance edge and the FSM SHALL enter HOLD (latency 1).
REQ-018 Normal double: Aexp = e11, Amant = {1, frac52, 11'b0}. Normal single: Aexp = e8 + 896, Amant = {1, frac23, 40'b0}.
REQ-019 Zero (exp=0, frac=0): Aexp = 0, Amant = 0, Azero = 1.
REQ-020 Infinity/NaN (exp all ones): Aexp = 2047 for both precisions; Amant = {0, fraction placed per REQ-012}; Ainf when frac=0, else Anan.
REQ-021 Denormal (exp=0, frac≠0): the acceptance edge SHALL load Amant = {0, fraction}, Aexp = 1 (double) or 897 (single), norm_shift = 0 and Adenorm = 1, then enter NORM.
REQ-022 Each NORM edge where Amant[63:56] = 0 SHALL shift Amant left by 8, subtract 8 from Aexp and add 8 to norm_shift.
REQ-023 Otherwise the NORM edge SHALL shift by the leading-zero count z (0..7) of Amant[63:56], subtract z from Aexp, add z to norm_shift and enter HOLD.
REQ-024 After normalization, Amant[63] SHALL be 1 and Aexp + norm_shift SHALL equal the REQ-021 start value.
REQ-025 In HOLD, outputs SHALL stay stable while out_ready = 0.
REQ-026 In HOLD with out_ready = 1 and no new input, the FSM SHALL go to IDLE and out_valid SHALL drop.
REQ-027 In HOLD with out_ready = 1 and in_valid = 1, the new operand SHALL be accepted on the same edge per REQ-017/REQ-021, giving one result per cycle.
REQ-028 in_valid SHALL be ignored in NORM; op and P SHALL be sampled only on the acceptance edge.
REQ-029 Invalid SHALL be set only with Anan, and SHALL be 0 for quiet NaNs.

Reset
REQ-030 While reset_n = 0, the FSM SHALL be IDLE and out_valid, Asign, Aexp, Amant, norm_shift, class flags and Invalid SHALL be 0; in_ready SHALL be 1 after release.
REQ-031 Reset asserted in NORM or HOLD SHALL abandon the operand immediately; no result for it SHALL ever appear.

Verification
REQ-032 Double 1.0: op=0x3FF0000000000000, P=0 -> next cycle out_valid, Aexp=1023, Amant=0x8000000000000000, all class flags 0.
REQ-033 Single 1.0: op=0x3F800000_xxxxxxxx, P=1 -> Aexp=1023, Amant=0x8000000000000000; single 0x7F7FFFFF -> Aexp=1150, Amant=0xFFFFFF0000000000.
REQ-034 Double minimum denormal: op=0x0000000000000001 -> 7 NORM cycles, out_valid 8 cycles after acceptance, Aexp=-51 (0xFCD), norm_shift=52, Amant=0x8000000000000000, Adenorm=1.
REQ-035 Specials: 0x7FF0000000000001 -> Anan=1, Invalid=1; 0x7FF8000000000000 -> Anan=1, Invalid=0; 0xFFF0000000000000 -> Ainf=1, Asign=1, Aexp=2047; 0x8000000000000000 -> Azero=1, Asign=1.
REQ-036 Backpressure/streaming: hold out_ready=0 for 5 cycles -> outputs unchanged and in_ready=0; then stream 4 normal operands with out_ready=1 -> 4 results on 4 consecutive cycles, in order.
REQ-037 Reset on the 3rd NORM cycle of 0x0000000000000001 -> outputs zero, IDLE, no stale out_valid after release.
